// File: rtl/vx_sau_pkg.sv
// Shared types and helpers for the SAU systolic GEMM engine.
package vx_sau_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } sau_state_e;

    // Width of the flush counter, which counts down from 2N-2.
    function automatic int flush_cnt_w(input int n);
        return (n > 1) ? $clog2(2 * n) : 1;
    endfunction

    // Width of a row index into an N-row array.
    function automatic int row_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of element i in a packed vector of w-bit elements.
    function automatic int elem_lsb(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/vx_sau_gemm_engine_mac_pe.sv
// One output-stationary PE: forwards A right and B down, accumulates a*b.
module vx_sau_mac_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  sgn,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    logic [DW-1:0]        a_d, a_q, b_d, b_q;
    logic [AW-1:0]        acc_d, acc_q;
    logic signed [PW-1:0] a_sx_s, b_sx_s, prod_s_s;
    logic [PW-1:0]        a_zx_s, b_zx_s, prod_u_s;
    logic [AW-1:0]        prod_ext_s;

    // Multiply, extend per operand mode, and form next accumulator value.
    always_comb begin
        a_d      = a_in;
        b_d      = b_in;
        a_sx_s   = PW'($signed(a_in));
        b_sx_s   = PW'($signed(b_in));
        a_zx_s   = PW'(a_in);
        b_zx_s   = PW'(b_in);
        prod_s_s = a_sx_s * b_sx_s;
        prod_u_s = a_zx_s * b_zx_s;
        if (sgn) begin
            prod_ext_s = AW'(prod_s_s);
        end else begin
            prod_ext_s = AW'(prod_u_s);
        end
        if (clr) begin
            acc_d = {AW{1'b0}};
        end else begin
            acc_d = acc_q + prod_ext_s;
        end
    end

    // Operand pass-through and accumulator registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= {DW{1'b0}};
            b_q   <= {DW{1'b0}};
            acc_q <= {AW{1'b0}};
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/vx_sau_gemm_engine.sv
// N x N output-stationary systolic GEMM engine: skewed operand feed,
// PE grid, job FSM and row-by-row result drain.
module vx_sau_gemm_engine
    import vx_sau_pkg::*;
#(
    parameter int MATRIX_SIZE = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_signed,
    input  logic                               cfg_accum,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]  in_a,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]  in_b,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MATRIX_SIZE*ACC_WIDTH-1:0]   out_row,
    output logic [row_idx_w(MATRIX_SIZE)-1:0]  out_row_idx,
    output logic                               out_last,
    output logic                               busy
);
    localparam int N   = MATRIX_SIZE;
    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ACC_WIDTH;
    localparam int RIW = row_idx_w(N);
    localparam int CW  = flush_cnt_w(N);
    // Last beat reaches PE(N-1,N-1) 2N-1 edges after acceptance.
    localparam logic [CW-1:0] FLUSH_INIT = CW'(2 * N - 2);

    sau_state_e      state_d, state_q;
    logic            sgn_d, sgn_q;
    logic [CW-1:0]   flush_cnt_d, flush_cnt_q;
    logic            in_ready_d, in_ready_q;
    logic            busy_d, busy_q;
    logic            out_valid_d, out_valid_q;
    logic            out_last_d, out_last_q;
    logic [RIW-1:0]  out_row_idx_d, out_row_idx_q;
    logic [N*AW-1:0] out_row_d, out_row_q;
    logic            accept_s;
    logic            clr_s;
    logic [RIW-1:0]  next_idx_s;
    logic [N*AW-1:0] mux_row_s;

    logic [DW-1:0]   a_feed_s [N];
    logic [DW-1:0]   b_feed_s [N];
    logic [DW-1:0]   a_pass_s [N][N];
    logic [DW-1:0]   b_pass_s [N][N];
    logic [AW-1:0]   acc_s    [N][N];

    assign accept_s = in_valid && in_ready_q;

    // Skew: operand i is delayed i cycles behind a common beat register;
    // cycles without an accepted beat feed zeros.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] a_sk_d [0:gi];
        logic [DW-1:0] a_sk_q [0:gi];
        logic [DW-1:0] b_sk_d [0:gi];
        logic [DW-1:0] b_sk_q [0:gi];

        // Next value of the row/column skew shift register.
        always_comb begin
            if (accept_s) begin
                a_sk_d[0] = in_a[elem_lsb(gi, DW) +: DW];
                b_sk_d[0] = in_b[elem_lsb(gi, DW) +: DW];
            end else begin
                a_sk_d[0] = {DW{1'b0}};
                b_sk_d[0] = {DW{1'b0}};
            end
            for (int s = 1; s <= gi; s++) begin
                a_sk_d[s] = a_sk_q[s-1];
                b_sk_d[s] = b_sk_q[s-1];
            end
        end

        // Skew shift register storage.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s <= gi; s++) begin
                    a_sk_q[s] <= {DW{1'b0}};
                    b_sk_q[s] <= {DW{1'b0}};
                end
            end else begin
                for (int s = 0; s <= gi; s++) begin
                    a_sk_q[s] <= a_sk_d[s];
                    b_sk_q[s] <= b_sk_d[s];
                end
            end
        end

        assign a_feed_s[gi] = a_sk_q[gi];
        assign b_feed_s[gi] = b_sk_q[gi];
    end

    // PE grid: A flows along rows, B flows down columns.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            logic [DW-1:0] a_in_s, b_in_s;
            if (gc == 0) begin : g_a_edge
                assign a_in_s = a_feed_s[gr];
            end else begin : g_a_mid
                assign a_in_s = a_pass_s[gr][gc-1];
            end
            if (gr == 0) begin : g_b_edge
                assign b_in_s = b_feed_s[gc];
            end else begin : g_b_mid
                assign b_in_s = b_pass_s[gr-1][gc];
            end
            vx_sau_mac_pe #(
                .DATA_WIDTH (DW),
                .ACC_WIDTH  (AW)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .clr   (clr_s),
                .sgn   (sgn_q),
                .a_in  (a_in_s),
                .b_in  (b_in_s),
                .a_out (a_pass_s[gr][gc]),
                .b_out (b_pass_s[gr][gc]),
                .acc   (acc_s[gr][gc])
            );
        end
    end

    // Drain mux: select the row to present after the coming edge.
    always_comb begin
        mux_row_s = {(N*AW){1'b0}};
        if (out_valid_q && (out_row_idx_q != RIW'(N - 1))) begin
            next_idx_s = out_row_idx_q + {{(RIW-1){1'b0}}, 1'b1};
        end else begin
            next_idx_s = {RIW{1'b0}};
        end
        for (int j = 0; j < N; j++) begin
            mux_row_s[j*AW +: AW] = acc_s[next_idx_s][j];
        end
    end

    // Job FSM: next state, mode latch, accumulator clear and drain outputs.
    always_comb begin
        state_d       = state_q;
        sgn_d         = sgn_q;
        flush_cnt_d   = flush_cnt_q;
        clr_s         = 1'b0;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_row_idx_d = out_row_idx_q;
        out_row_d     = out_row_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sgn_d = cfg_signed;
                    clr_s = !cfg_accum;
                    if (in_last) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && in_last) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == {CW{1'b0}}) begin
                    state_d = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    // First DRAIN cycle: present row 0.
                    out_valid_d   = 1'b1;
                    out_row_idx_d = {RIW{1'b0}};
                    out_last_d    = 1'b0;
                    out_row_d     = mux_row_s;
                end else if (out_ready) begin
                    if (out_row_idx_q == RIW'(N - 1)) begin
                        out_valid_d   = 1'b0;
                        out_last_d    = 1'b0;
                        out_row_idx_d = {RIW{1'b0}};
                        state_d       = ST_IDLE;
                    end else begin
                        out_row_idx_d = next_idx_s;
                        out_last_d    = (next_idx_s == RIW'(N - 1));
                        out_row_d     = mux_row_s;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d     = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sgn_q         <= 1'b0;
            flush_cnt_q   <= {CW{1'b0}};
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_row_idx_q <= {RIW{1'b0}};
            out_row_q     <= {(N*AW){1'b0}};
        end else begin
            state_q       <= state_d;
            sgn_q         <= sgn_d;
            flush_cnt_q   <= flush_cnt_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_row_idx_q <= out_row_idx_d;
            out_row_q     <= out_row_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_row_idx = out_row_idx_q;
    assign out_row     = out_row_q;

endmodule

// File: tb/tb_vx_sau_gemm_engine.sv
// Directed bench for vx_sau_gemm_engine at N=2, DW=8, AW=16.
module tb_vx_sau_gemm_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_signed = 1'b0;
    logic        cfg_accum = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_row;
    logic [0:0]  out_row_idx;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;

    vx_sau_gemm_engine #(
        .MATRIX_SIZE (2),
        .DATA_WIDTH  (8),
        .ACC_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_signed  (cfg_signed),
        .cfg_accum   (cfg_accum),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Present one beat and wait (bounded) for its acceptance edge.
    task automatic beat(input logic [7:0] a0, a1, b0, b1, input logic last, sg, ac);
        int w;
        w = 0;
        @(negedge clk);
        in_a = {a1, a0}; in_b = {b1, b0}; in_last = last;
        cfg_signed = sg; cfg_accum = ac; in_valid = 1'b1;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        n_cmp++;
        if (!in_ready) begin n_err++; $display("FAIL beat_accept: in_ready=%b required 1", in_ready); end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Wait for results, optionally stall, then drain both rows; returns observations.
    task automatic collect(input int hold, output logic [31:0] r0, r1, output logic [0:0] i0, i1,
                           output logic l0, l1, output int lat, output bit rdy_low,
                           output bit stable, output bit tmo, output bit done_ok);
        int w;
        logic [31:0] first;
        rdy_low = 1'b1; stable = 1'b1; tmo = 1'b0; w = 0;
        r0 = 32'h0; r1 = 32'h0; i0 = 1'b0; i1 = 1'b0; l0 = 1'b0; l1 = 1'b0; done_ok = 1'b0;
        @(negedge clk);
        while (!out_valid && w < 60) begin
            if (in_ready) rdy_low = 1'b0;
            @(negedge clk); w++;
        end
        lat = cyc - acc_cyc;
        if (!out_valid) begin tmo = 1'b1; return; end
        first = out_row;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_row_idx !== 1'b0 || out_row !== first) stable = 1'b0;
        end
        r0 = out_row; i0 = out_row_idx; l0 = out_last;
        if (in_ready) rdy_low = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        if (!out_valid) tmo = 1'b1;
        r1 = out_row; i1 = out_row_idx; l1 = out_last;
        if (in_ready) rdy_low = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        done_ok = !out_valid && !busy && in_ready && !out_last;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (out_last !== 1'b0 || out_row_idx !== 1'b0) begin n_err++; $display("FAIL rst_last_idx: got %b/%b required 0/0", out_last, out_row_idx); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] r0, r1; logic [0:0] i0, i1; logic l0, l1; int lat; bit rl, st, tmo, dn;
        beat(8'd1, 8'd3, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_load: got %b required 1", busy); end
        beat(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, 1'b0, 1'b0);
        collect(0, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %b required 0", tmo); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL basic_latency: got %0d required 4", lat); end
        n_cmp++; if (r0 !== {16'd22, 16'd19}) begin n_err++; $display("FAIL basic_row0: got %h required %h", r0, {16'd22, 16'd19}); end
        n_cmp++; if (r1 !== {16'd50, 16'd43}) begin n_err++; $display("FAIL basic_row1: got %h required %h", r1, {16'd50, 16'd43}); end
        n_cmp++; if (i0 !== 1'b0 || i1 !== 1'b1) begin n_err++; $display("FAIL basic_idx: got %b,%b required 0,1", i0, i1); end
        n_cmp++; if (l0 !== 1'b0 || l1 !== 1'b1) begin n_err++; $display("FAIL basic_last: got %b,%b required 0,1", l0, l1); end
        n_cmp++; if (rl !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_low: got %b required 1", rl); end
        n_cmp++; if (dn !== 1'b1) begin n_err++; $display("FAIL basic_done_idle: got %b required 1", dn); end
    endtask

    task automatic test_accum();
        logic [31:0] r0, r1; logic [0:0] i0, i1; logic l0, l1; int lat; bit rl, st, tmo, dn;
        beat(8'd1, 8'd3, 8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
        beat(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, 1'b0, 1'b1);
        collect(0, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (r0 !== {16'd44, 16'd38}) begin n_err++; $display("FAIL accum_row0: got %h required %h", r0, {16'd44, 16'd38}); end
        n_cmp++; if (r1 !== {16'd100, 16'd86}) begin n_err++; $display("FAIL accum_row1: got %h required %h", r1, {16'd100, 16'd86}); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL accum_latency: got %0d required 4", lat); end
    endtask

    task automatic test_single_beat();
        logic [31:0] r0, r1; logic [0:0] i0, i1; logic l0, l1; int lat; bit rl, st, tmo, dn;
        beat(8'hFF, 8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1'b0);
        collect(0, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (r0 !== {16'hFFFD, 16'hFFFE}) begin n_err++; $display("FAIL signed_row0: got %h required %h", r0, {16'hFFFD, 16'hFFFE}); end
        n_cmp++; if (r1 !== {16'd3, 16'd2}) begin n_err++; $display("FAIL signed_row1: got %h required %h", r1, {16'd3, 16'd2}); end
        n_cmp++; if (lat != 4) begin n_err++; $display("FAIL single_latency: got %0d required 4", lat); end
        beat(8'hFF, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0);
        collect(0, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (r0 !== {16'd765, 16'd510}) begin n_err++; $display("FAIL unsigned_row0: got %h required %h", r0, {16'd765, 16'd510}); end
        n_cmp++; if (r1 !== {16'd3, 16'd2}) begin n_err++; $display("FAIL unsigned_row1: got %h required %h", r1, {16'd3, 16'd2}); end
    endtask

    task automatic test_wrap_hold();
        logic [31:0] r0, r1; logic [0:0] i0, i1; logic l0, l1; int lat; bit rl, st, tmo, dn;
        beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        collect(5, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (st !== 1'b1) begin n_err++; $display("FAIL hold_stable: got %b required 1", st); end
        n_cmp++; if (r0 !== {16'd64514, 16'd64514}) begin n_err++; $display("FAIL wrap_row0: got %h required %h", r0, {16'd64514, 16'd64514}); end
        n_cmp++; if (r1 !== {16'd64514, 16'd64514}) begin n_err++; $display("FAIL wrap_row1: got %h required %h", r1, {16'd64514, 16'd64514}); end
        n_cmp++; if (i0 !== 1'b0 || l0 !== 1'b0) begin n_err++; $display("FAIL hold_idx_last: got %b/%b required 0/0", i0, l0); end
    endtask

    task automatic test_gaps();
        logic [31:0] r0, r1; logic [0:0] i0, i1; logic l0, l1; int lat; bit rl, st, tmo, dn;
        beat(8'd1, 8'd3, 8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL gap_in_ready: got %b required 1", in_ready); end
        beat(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, 1'b0, 1'b0);
        collect(0, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (r0 !== {16'd22, 16'd19}) begin n_err++; $display("FAIL gap_row0: got %h required %h", r0, {16'd22, 16'd19}); end
        n_cmp++; if (r1 !== {16'd50, 16'd43}) begin n_err++; $display("FAIL gap_row1: got %h required %h", r1, {16'd50, 16'd43}); end
        n_cmp++; if (rl !== 1'b1) begin n_err++; $display("FAIL gap_in_ready_low: got %b required 1", rl); end
    endtask

    task automatic test_reset_midjob();
        logic [31:0] r0, r1; logic [0:0] i0, i1; logic l0, l1; int lat; bit rl, st, tmo, dn;
        beat(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs: got rdy=%b vld=%b busy=%b required 0/0/0", in_ready, out_valid, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        beat(8'd1, 8'd3, 8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
        beat(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, 1'b0, 1'b1);
        collect(0, r0, r1, i0, i1, l0, l1, lat, rl, st, tmo, dn);
        n_cmp++; if (r0 !== {16'd22, 16'd19}) begin n_err++; $display("FAIL midrst_row0: got %h required %h", r0, {16'd22, 16'd19}); end
        n_cmp++; if (r1 !== {16'd50, 16'd43}) begin n_err++; $display("FAIL midrst_row1: got %h required %h", r1, {16'd50, 16'd43}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accum();
        test_single_beat();
        test_wrap_hold();
        test_gaps();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
